// File: rtl/ili_bus_ctrl.sv
// ili_bus_ctrl -- memory-mapped write engine for an ILI-style 8080 panel bus.
//
// Host side (register slave, writes take effect on the clock edge where
// chipselect=1 and write_n=0; readdata is purely combinational on address):
//   clk, reset_n          single clock, asynchronous active-low reset
//   address[1:0]          0 CMD, 1 DATA, 2 STATUS, 3 CFG
//   chipselect, write_n   slave select and active-low write strobe
//   writedata[31:0]       write data (CMD/DATA use [15:0], CFG uses [7:0])
//   readdata[31:0]        STATUS = {level[7:4], 0, ovf, full, busy}, CFG = cfg
// Panel side (all registered):
//   lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db[15:0]
//
// CMD/DATA writes queue {rs, data} in a FIFO. The transfer FSM drains it with
// a SETUP cycle, a LOW phase of cfg[3:0]+1 cycles and a HIGH phase of
// cfg[7:4]+1 cycles. Consecutive entries chain without releasing chip select.
module ili_bus_ctrl #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] CFG_RESET  = 8'h22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_db
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, WR_LOW, WR_HIGH} state_t;

  state_t           state;
  logic [16:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic [7:0]       cfg;
  logic [7:0]       cfg_work;
  logic [3:0]       phase_cnt;

  logic             wr_en;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             phase_done;
  logic             busy;
  logic [16:0]      head;
  logic [3:0]       level_rd;
  logic             unused_wdata;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_en      = chipselect && !write_n;
  assign push_req   = wr_en && (address == 2'd0 || address == 2'd1);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign phase_done = (state == WR_HIGH) && (phase_cnt == cfg_work[7:4]);
  assign pop        = !fifo_empty && ((state == IDLE) || phase_done);
  // A push into a full FIFO still fits when the same edge frees the head slot.
  assign push       = push_req && (!fifo_full || pop);
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;
  assign level_rd   = 4'(level);
  assign lcd_rd_n   = 1'b1;
  assign unused_wdata = ^writedata[31:16];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {address[0], writedata[15:0]};
    end
  end

  // FIFO control, overflow flag and timing register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      cfg    <= CFG_RESET;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (push_req && !push) begin
        ovf <= 1'b1;
      end else if (wr_en && address == 2'd2) begin
        ovf <= 1'b0;
      end
      if (wr_en && address == 2'd3) begin
        cfg <= writedata[7:0];
      end
    end
  end

  // Transfer FSM; every panel output is registered here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      cfg_work  <= CFG_RESET;
      lcd_cs_n  <= 1'b1;
      lcd_wr_n  <= 1'b1;
      lcd_rs    <= 1'b1;
      lcd_db    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SETUP;
            lcd_cs_n <= 1'b0;
            lcd_rs   <= head[16];
            lcd_db   <= head[15:0];
            cfg_work <= cfg;
          end
        end
        SETUP: begin
          state     <= WR_LOW;
          phase_cnt <= '0;
          lcd_wr_n  <= 1'b0;
        end
        WR_LOW: begin
          if (phase_cnt == cfg_work[3:0]) begin
            state     <= WR_HIGH;
            phase_cnt <= '0;
            lcd_wr_n  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        WR_HIGH: begin
          if (phase_done) begin
            if (pop) begin
              // chain straight into the next entry, chip select stays low
              state    <= SETUP;
              lcd_rs   <= head[16];
              lcd_db   <= head[15:0];
              cfg_work <= cfg;
            end else begin
              state    <= IDLE;
              lcd_cs_n <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          lcd_cs_n <= 1'b1;
          lcd_wr_n <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd2:    readdata[7:0] = {level_rd, 1'b0, ovf, fifo_full, busy};
      2'd3:    readdata[7:0] = cfg;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ili_bus_ctrl.sv
// Self-checking bench for ili_bus_ctrl. Queued words go into exp_q as they are
// written; a negedge monitor turns each panel write strobe into an observed
// transfer record that the scenario tasks pop and compare.
module tb_ili_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic [15:0] lcd_db;

  typedef struct {
    logic        rs;
    logic [15:0] db;
    int          low;
    int          lead;
  } xfer_t;

  xfer_t       obs_q[$];
  logic [16:0] exp_q[$];
  int          cs_q[$];

  int checks = 0;
  int errors = 0;
  int rd_viol = 0;
  int stab_err = 0;

  int    mon_cs_run = 0;
  int    mon_low_run = 0;
  logic  mon_prev_wr = 1'b1;
  xfer_t mon_pend;

  always #5 clk = ~clk;

  ili_bus_ctrl #(.FIFO_DEPTH(8), .CFG_RESET(8'h22)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_rs     (lcd_rs),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_rd_n   (lcd_rd_n),
    .lcd_db     (lcd_db)
  );

  // Panel monitor
  initial begin
    mon_pend = '{rs: 1'b0, db: 16'h0, low: 0, lead: 0};
    forever begin
      @(negedge clk);
      if (lcd_rd_n !== 1'b1) rd_viol++;
      if (lcd_cs_n === 1'b0) begin
        mon_cs_run++;
      end else if (mon_cs_run != 0) begin
        cs_q.push_back(mon_cs_run);
        mon_cs_run = 0;
      end
      if (lcd_wr_n === 1'b0) begin
        if (mon_prev_wr === 1'b1) begin
          mon_pend.rs   = lcd_rs;
          mon_pend.db   = lcd_db;
          mon_pend.lead = mon_cs_run - 1;
        end else if (lcd_rs !== mon_pend.rs || lcd_db !== mon_pend.db) begin
          stab_err++;
        end
        mon_low_run++;
      end else if (mon_prev_wr === 1'b0) begin
        mon_pend.low = mon_low_run;
        obs_q.push_back(mon_pend);
        mon_low_run = 0;
      end
      mon_prev_wr = lcd_wr_n;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push_word(input logic rs, input logic [15:0] d);
    exp_q.push_back({rs, d});
    bus_write({1'b0, rs}, {16'h0, d});
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_xfers(input int n_x, input int n_cs, input int limit, output bit ok);
    int k = 0;
    while ((obs_q.size() < n_x || cs_q.size() < n_cs) && k < limit) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n_x) && (cs_q.size() >= n_cs);
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
    cs_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (lcd_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", lcd_cs_n); end
    checks++; if (lcd_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b expected 1", lcd_wr_n); end
    checks++; if (lcd_rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b expected 1", lcd_rd_n); end
    checks++; if (lcd_rs !== 1'b1) begin errors++; $display("FAIL reset_rs: got %b expected 1", lcd_rs); end
    checks++; if (lcd_db !== 16'h0) begin errors++; $display("FAIL reset_db: got %h expected 0000", lcd_db); end
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 00000000", rd); end
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL reset_cfg: got %h expected 00000022", rd); end
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL read_cmd_zero: got %h expected 00000000", rd); end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    logic [16:0] e;
    xfer_t o;
    bit ok;
    clear_queues();
    push_word(1'b0, 16'h002A);
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL single_status_queued: got %h expected 00000011", rd); end
    wait_xfers(1, 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d transfers expected 1", obs_q.size()); end
    if (ok) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o.rs !== e[16]) begin errors++; $display("FAIL single_rs: got %b expected %b", o.rs, e[16]); end
      checks++; if (o.db !== e[15:0]) begin errors++; $display("FAIL single_db: got %h expected %h", o.db, e[15:0]); end
      checks++; if (o.low != 3) begin errors++; $display("FAIL single_wr_low_len: got %0d expected 3", o.low); end
      checks++; if (o.lead != 1) begin errors++; $display("FAIL single_setup_len: got %0d expected 1", o.lead); end
      checks++; if (cs_q[0] != 7) begin errors++; $display("FAIL single_cs_len: got %0d expected 7", cs_q[0]); end
    end
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL single_status_idle: got %h expected 00000000", rd); end
  endtask

  task automatic test_burst();
    logic [16:0] e;
    xfer_t o;
    bit ok;
    clear_queues();
    bus_write(2'd3, 32'h00);
    push_word(1'b0, 16'h002C);
    push_word(1'b1, 16'hF800);
    push_word(1'b1, 16'h07E0);
    wait_xfers(3, 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d transfers expected 3", obs_q.size()); end
    while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o.rs !== e[16]) begin errors++; $display("FAIL burst_rs: got %b expected %b", o.rs, e[16]); end
      checks++; if (o.db !== e[15:0]) begin errors++; $display("FAIL burst_db: got %h expected %h", o.db, e[15:0]); end
      checks++; if (o.low != 1) begin errors++; $display("FAIL burst_wr_low_len: got %0d expected 1", o.low); end
    end
    if (ok) begin
      checks++; if (cs_q[0] != 9) begin errors++; $display("FAIL burst_cs_len: got %0d expected 9", cs_q[0]); end
    end
  endtask

  task automatic test_cfg_change();
    logic [31:0] rd;
    logic [16:0] e;
    xfer_t o;
    bit ok;
    int k;
    int exp_low[2];
    clear_queues();
    exp_low[0] = 3;
    exp_low[1] = 2;
    bus_write(2'd3, 32'h22);
    push_word(1'b0, 16'h1111);
    push_word(1'b1, 16'h2222);
    k = 0;
    while (lcd_wr_n !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    checks++; if (lcd_wr_n !== 1'b0) begin errors++; $display("FAIL cfgchg_wr_low_timeout: got %b expected 0", lcd_wr_n); end
    bus_write(2'd3, 32'h11);
    wait_xfers(2, 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cfgchg_timeout: got %0d transfers expected 2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++; if (o.db !== e[15:0]) begin errors++; $display("FAIL cfgchg_db: got %h expected %h", o.db, e[15:0]); end
        checks++; if (o.low != exp_low[i]) begin errors++; $display("FAIL cfgchg_wr_low_len: got %0d expected %0d", o.low, exp_low[i]); end
      end
    end
    if (ok) begin
      checks++; if (cs_q[0] != 12) begin errors++; $display("FAIL cfgchg_cs_len: got %0d expected 12", cs_q[0]); end
    end
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL cfgchg_cfg_read: got %h expected 00000011", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [16:0] e;
    xfer_t o;
    bit ok;
    clear_queues();
    bus_write(2'd3, 32'hFF);
    push_word(1'b0, 16'h0C0C);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_word(1'b1, 16'hA000 + 16'(i));
      else       bus_write(2'd1, 32'h0000_A000 + 32'(i));
    end
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h87) begin errors++; $display("FAIL ovf_status: got %h expected 00000087", rd); end
    bus_write(2'd2, 32'h0);
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL ovf_clear_status: got %h expected 00000083", rd); end
    wait_xfers(9, 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got %0d transfers expected 9", obs_q.size()); end
    while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o.rs !== e[16]) begin errors++; $display("FAIL ovf_rs: got %b expected %b", o.rs, e[16]); end
      checks++; if (o.db !== e[15:0]) begin errors++; $display("FAIL ovf_db: got %h expected %h", o.db, e[15:0]); end
      checks++; if (o.low != 16) begin errors++; $display("FAIL ovf_wr_low_len: got %0d expected 16", o.low); end
    end
    if (ok) begin
      checks++; if (cs_q[0] != 297) begin errors++; $display("FAIL ovf_cs_len: got %0d expected 297", cs_q[0]); end
    end
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovf_status_drained: got %h expected 00000000", rd); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    logic [16:0] e;
    xfer_t o;
    bit ok;
    bit seen;
    logic prev;
    clear_queues();
    bus_write(2'd3, 32'hFF);
    push_word(1'b0, 16'h0D0D);
    for (int i = 0; i < 8; i++) push_word(1'b1, 16'hB000 + 16'(i));
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL full_status_before: got %h expected 00000083", rd); end
    seen = 1'b0;
    prev = lcd_wr_n;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (prev === 1'b0 && lcd_wr_n === 1'b1) seen = 1'b1;
      prev = lcd_wr_n;
    end
    checks++; if (!seen) begin errors++; $display("FAIL full_wr_rise_timeout: got %b expected 1", seen); end
    // the head pops HIGH+1 = 16 edges after the strobe rises
    repeat (15) @(posedge clk);
    push_word(1'b1, 16'hBEEF);
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL full_pushpop_status: got %h expected 00000083", rd); end
    wait_xfers(10, 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got %0d transfers expected 10", obs_q.size()); end
    while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o.rs !== e[16]) begin errors++; $display("FAIL full_rs: got %b expected %b", o.rs, e[16]); end
      checks++; if (o.db !== e[15:0]) begin errors++; $display("FAIL full_db: got %h expected %h", o.db, e[15:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int k;
    clear_queues();
    bus_write(2'd3, 32'h33);
    bus_write(2'd1, 32'h1234);
    bus_write(2'd1, 32'h5678);
    k = 0;
    while (lcd_wr_n !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    checks++; if (lcd_wr_n !== 1'b0) begin errors++; $display("FAIL rstmid_wr_low_timeout: got %b expected 0", lcd_wr_n); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (lcd_wr_n !== 1'b1) begin errors++; $display("FAIL rstmid_wr_n: got %b expected 1", lcd_wr_n); end
    checks++; if (lcd_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n: got %b expected 1", lcd_cs_n); end
    checks++; if (lcd_rs !== 1'b1) begin errors++; $display("FAIL rstmid_rs: got %b expected 1", lcd_rs); end
    checks++; if (lcd_db !== 16'h0) begin errors++; $display("FAIL rstmid_db: got %h expected 0000", lcd_db); end
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_status: got %h expected 00000000", rd); end
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL rstmid_cfg: got %h expected 00000022", rd); end
    repeat (3) @(negedge clk);
    clear_queues();
    repeat (20) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_strobes: got %0d transfers expected 0", obs_q.size()); end
    checks++; if (lcd_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_idle: got %b expected 1", lcd_cs_n); end
  endtask

  task automatic test_bus_invariants();
    checks++; if (rd_viol != 0) begin errors++; $display("FAIL rd_n_held_high: got %0d low samples expected 0", rd_viol); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rs_db_stable: got %0d changes expected 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_cfg_change();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_bus_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ili_bus_ctrl.md
ILI_BUS_CTRL -- requirements
Module: ili_bus_ctrl

Interface
REQ-001 Parameters: FIFO_DEPTH, default 8, number of queued bus writes; CFG_RESET, default 8'h22, reset value of the timing register.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, the single clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data.
- lcd_cs_n, output, 1, panel chip select.
- lcd_rs, output, 1, panel command/data select (0 = command, 1 = data).
- lcd_wr_n, output, 1, panel write strobe.
- lcd_rd_n, output, 1, panel read strobe.
- lcd_db, output, 16, panel data bus.
REQ-003 One clock; reset is asynchronous and active-low.
- Clock port: clk.
- Reset port: reset_n.

Function
REQ-004 Register map, accessed when chipselect=1:
- 0 CMD: write pushes {rs=0, writedata[15:0]}.
- 1 DATA: write pushes {rs=1, writedata[15:0]}.
- 2 STATUS: read-only; any write clears the overflow flag.
- 3 CFG: read/write; [3:0] LOW, [7:4] HIGH.
REQ-005 STATUS read layout:
- bit0 busy (FSM not IDLE or FIFO not empty).
- bit1 FIFO full.
- bit2 sticky overflow.
- bits[7:4] FIFO level.
- all other bits 0.
REQ-006 readdata is combinational from address; CMD and DATA read 0; CFG reads {24'b0, cfg}.
REQ-007 The FIFO stores FIFO_DEPTH entries of 17 bits, {rs, data}, in first-in first-out order.
REQ-008 A push to a full FIFO is discarded and sets overflow; FIFO contents and level are unchanged.
REQ-009 Push and pop in the same cycle both take effect and the level is unchanged.
- When the FIFO is full, the simultaneous push is accepted because a slot is freed.
REQ-010 FSM states: IDLE, SETUP, WR_LOW, WR_HIGH.
REQ-011 IDLE with FIFO not empty: pop the head, latch rs/data to lcd_rs/lcd_db, latch cfg into a working copy, and go to SETUP next cycle.
REQ-012 SETUP lasts exactly 1 cycle: lcd_cs_n=0, lcd_wr_n=1, lcd_rs and lcd_db valid.
REQ-013 WR_LOW lasts LOW+1 cycles with lcd_wr_n=0.
REQ-014 WR_HIGH lasts HIGH+1 cycles with lcd_wr_n=1; lcd_rs and lcd_db are held stable.
REQ-015 End of WR_HIGH with FIFO not empty: pop and latch the next entry, then go to SETUP; lcd_cs_n stays 0 with no deassertion gap.
REQ-016 End of WR_HIGH with FIFO empty: go to IDLE; lcd_cs_n=1 from the IDLE cycle onward.
REQ-017 A CFG write during a transfer does not affect the transfer in progress; the new value applies from the next pop.
REQ-018 lcd_rd_n is held at 1 at all times.
REQ-019 In IDLE, lcd_rs and lcd_db keep their last driven values.
REQ-020 Phase counters are 4 bits; LOW=0 and HIGH=0 give 1-cycle phases, so the minimum transfer is 3 clocks.
REQ-021 No input combination stalls the FSM; a write to an unused field has no effect.

Reset
REQ-022 Asserting reset_n low forces, immediately and asynchronously:
- FSM to IDLE; FIFO empty; overflow=0; cfg=CFG_RESET.
- lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=1, lcd_db=0.
REQ-023 Reset during a transfer aborts it with no further panel strobes; queued entries are lost.
REQ-024 After reset_n rises, the first pop occurs no earlier than the first clock edge on which the FIFO is non-empty.

Verification
REQ-025 Single command: CFG default, write CMD 16'h002A. Required response:
- lcd_cs_n low for 7 cycles, lcd_rs=0, lcd_db=16'h002A.
- lcd_wr_n low for exactly 3 cycles, starting 1 cycle after lcd_cs_n falls.
- then lcd_cs_n=1 and busy=0.
REQ-026 Burst: CFG=8'h00, write CMD 16'h002C then DATA 16'hF800, 16'h07E0 back-to-back. Required response:
- three 3-cycle transfers with lcd_rs sequence 0,1,1.
- lcd_cs_n continuously low for 9 cycles.
REQ-027 Overflow: with the bus stalled by CFG=8'hFF, write 9 DATA words. Required response:
- STATUS reads full=1, overflow=1, level=8.
- exactly 8 transfers occur, with the 9th value absent.
- a STATUS write clears overflow.
REQ-028 Full-FIFO simultaneous push/pop: push while FIFO is full on the cycle a pop happens. Required response: entry accepted, overflow stays 0, level stays 8.
REQ-029 Reset mid-transfer: assert reset_n during WR_LOW. Required response:
- lcd_wr_n=1, lcd_cs_n=1, lcd_rs=1, lcd_db=0 without waiting for a clock edge.
- STATUS=0 after release.
REQ-030 CFG change mid-transfer: write CFG=8'h11 during WR_LOW of a CFG=8'h22 transfer. Required response:
- the current transfer keeps 3-cycle phases.
- the next transfer uses 2-cycle phases.
